// File: rtl/df_swt_pkg.sv
// Shared types, widths and the Goertzel coefficient table for the df_swt peak finder.
package df_swt_pkg;

  localparam int N    = 128;
  localparam int LOGN = 7;
  localparam int DW   = 16;
  localparam int AW   = 40;   // s0/s1/s2 accumulator width
  localparam int CW   = 19;   // Q3.16 coefficient width
  localparam int PW   = 64;   // power width

  typedef enum logic [1:0] {CAPTURE, COMPUTE, DONE} state_e;

  // c_k = round(2*cos(2*pi*k/128) * 2^16)
  function automatic logic signed [CW-1:0] coef(input logic [5:0] k);
    logic signed [CW-1:0] c;
    c = '0;
    case (k)
      6'd0:  c =  19'sd131072;  6'd1:  c =  19'sd130914;
      6'd2:  c =  19'sd130441;  6'd3:  c =  19'sd129653;
      6'd4:  c =  19'sd128553;  6'd5:  c =  19'sd127144;
      6'd6:  c =  19'sd125428;  6'd7:  c =  19'sd123410;
      6'd8:  c =  19'sd121095;  6'd9:  c =  19'sd118488;
      6'd10: c =  19'sd115595;  6'd11: c =  19'sd112424;
      6'd12: c =  19'sd108982;  6'd13: c =  19'sd105278;
      6'd14: c =  19'sd101320;  6'd15: c =  19'sd97118;
      6'd16: c =  19'sd92682;   6'd17: c =  19'sd88023;
      6'd18: c =  19'sd83151;   6'd19: c =  19'sd78079;
      6'd20: c =  19'sd72820;   6'd21: c =  19'sd67384;
      6'd22: c =  19'sd61787;   6'd23: c =  19'sd56041;
      6'd24: c =  19'sd50159;   6'd25: c =  19'sd44157;
      6'd26: c =  19'sd38048;   6'd27: c =  19'sd31848;
      6'd28: c =  19'sd25571;   6'd29: c =  19'sd19232;
      6'd30: c =  19'sd12847;   6'd31: c =  19'sd6431;
      6'd32: c =  19'sd0;       6'd33: c = -19'sd6431;
      6'd34: c = -19'sd12847;   6'd35: c = -19'sd19232;
      6'd36: c = -19'sd25571;   6'd37: c = -19'sd31848;
      6'd38: c = -19'sd38048;   6'd39: c = -19'sd44157;
      6'd40: c = -19'sd50159;   6'd41: c = -19'sd56041;
      6'd42: c = -19'sd61787;   6'd43: c = -19'sd67384;
      6'd44: c = -19'sd72820;   6'd45: c = -19'sd78079;
      6'd46: c = -19'sd83151;   6'd47: c = -19'sd88023;
      6'd48: c = -19'sd92682;   6'd49: c = -19'sd97118;
      6'd50: c = -19'sd101320;  6'd51: c = -19'sd105278;
      6'd52: c = -19'sd108982;  6'd53: c = -19'sd112424;
      6'd54: c = -19'sd115595;  6'd55: c = -19'sd118488;
      6'd56: c = -19'sd121095;  6'd57: c = -19'sd123410;
      6'd58: c = -19'sd125428;  6'd59: c = -19'sd127144;
      6'd60: c = -19'sd128553;  6'd61: c = -19'sd129653;
      6'd62: c = -19'sd130441;  6'd63: c = -19'sd130914;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/df_swt_goertzel.sv
// Serial Goertzel recursion for one bin; power appears one cycle after the last
// iteration and pvalid_o marks it for one cycle.
module df_swt_goertzel
  import df_swt_pkg::*;
#(
  parameter int SW = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic signed [SW-1:0] sample_i,
  input  logic signed [CW-1:0] coef_i,
  input  logic                 start_i,
  input  logic                 last_i,
  output logic [PW-1:0]        power_o,
  output logic                 pvalid_o
);

  logic signed [AW-1:0] s1_q, s2_q, s1_d, s2_d, s1e, s2e;
  logic signed [63:0]   prod, m;
  logic signed [95:0]   pfull;
  logic [PW-1:0]        power_q, power_d;
  logic                 last_q, pvalid_q;

  always_comb begin
    // start_i zeroes the history so a bin never sees the previous bin's state
    s1e   = start_i ? '0 : s1_q;
    s2e   = start_i ? '0 : s2_q;
    prod  = 64'(coef_i) * 64'(s1e);
    m     = prod >>> 16;
    s1_d  = AW'(sample_i) + AW'(m) - s2e;
    s2_d  = s1e;
    pfull = 96'(s1_q) * 96'(s1_q) + 96'(s2_q) * 96'(s2_q) - 96'(m) * 96'(s2_q);
    // rounding can push a tiny result negative; clamp low, saturate high
    if (pfull[95])             power_d = '0;
    else if (|pfull[95:PW])    power_d = '1;
    else                       power_d = pfull[PW-1:0];
  end

  // The recursion free-runs; only the window between start_i and last_i is meaningful.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      last_q   <= 1'b0;
      pvalid_q <= 1'b0;
      power_q  <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      last_q   <= last_i;
      pvalid_q <= last_q;
      if (last_q) power_q <= power_d;
    end
  end

  assign power_o  = power_q;
  assign pvalid_o = pvalid_q;

endmodule

// File: rtl/df_swt.sv
// Block DFT peak finder: capture N samples, Goertzel-scan bins 1..N/2-1, report the argmax.
module df_swt
  import df_swt_pkg::*;
#(
  parameter int N    = 128,
  parameter int LOGN = 7,
  parameter int DW   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic signed [DW-1:0] datain,
  output logic [LOGN-2:0]      freqbin,
  output logic                 valid
);

  localparam int KLAST = N/2 - 1;

  state_e               state_q, state_d;
  logic [LOGN:0]        cnt_q, cnt_d;      // capture index, then cycle within a bin
  logic [LOGN-2:0]      k_q, k_d, bestk_q, bestk_d, freqbin_q, freqbin_d;
  logic [PW-1:0]        best_q, best_d, power;
  logic                 valid_q, valid_d;
  logic                 we, start, last, pvalid;
  logic signed [DW-1:0] mem_q [N];
  logic signed [DW-1:0] x;

  assign x = mem_q[cnt_q[LOGN-1:0]];

  always_ff @(posedge clock) begin
    if (we) mem_q[cnt_q[LOGN-1:0]] <= datain;
  end

  df_swt_goertzel #(.SW(DW)) u_gz (
    .clock    (clock),
    .reset    (reset),
    .sample_i (x),
    .coef_i   (coef(k_q)),
    .start_i  (start),
    .last_i   (last),
    .power_o  (power),
    .pvalid_o (pvalid)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    best_d    = best_q;
    bestk_d   = bestk_q;
    freqbin_d = freqbin_q;
    valid_d   = 1'b0;
    we        = 1'b0;
    start     = 1'b0;
    last      = 1'b0;
    case (state_q)
      CAPTURE: begin
        if (enable) begin
          we = 1'b1;
          if (cnt_q == (LOGN+1)'(N-1)) begin
            cnt_d   = '0;
            k_d     = (LOGN-1)'(1);
            state_d = COMPUTE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        start = (cnt_q == '0);
        last  = (cnt_q == (LOGN+1)'(N-1));
        // pvalid lands on the compare cycle, the last of the bin's N+2
        if (pvalid) begin
          if (k_q == (LOGN-1)'(1) || power > best_q) begin
            best_d  = power;
            bestk_d = k_q;
          end
          cnt_d = '0;
          if (k_q == (LOGN-1)'(KLAST)) state_d = DONE;
          else                         k_d     = k_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        freqbin_d = bestk_q;
        valid_d   = 1'b1;
        cnt_d     = '0;
        state_d   = CAPTURE;
      end
      default: state_d = CAPTURE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= CAPTURE;
      cnt_q     <= '0;
      k_q       <= '0;
      best_q    <= '0;
      bestk_q   <= '0;
      freqbin_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      best_q    <= best_d;
      bestk_q   <= bestk_d;
      freqbin_q <= freqbin_d;
      valid_q   <= valid_d;
    end
  end

  assign freqbin = freqbin_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_df_swt.sv
// Directed bench for df_swt: expected bins and valid times go into a scoreboard
// when a window is sent and are checked when valid pulses.
module tb_df_swt;

  localparam int LAT = 8191;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               enable = 1'b0;
  logic signed [15:0] datain = '0;
  logic [5:0]         freqbin;
  logic               valid;

  df_swt dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .datain  (datain),
    .freqbin (freqbin),
    .valid   (valid)
  );

  always #5 clock = ~clock;

  typedef struct { int bin; int due; } exp_t;
  exp_t sb_q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_chk = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) n_pass++;
    else $error("FAIL %s got=%0d want=%0d cyc=%0d", tag, got, want, cyc);
  endtask

  function automatic logic signed [15:0] tone(input int kind, input int n);
    real ph, v;
    ph = 2.0 * 3.14159265358979 * n / 128.0;
    case (kind)
      1:       v = 8000.0 * $sin(10.0 * ph);
      2:       v = 12000.0 * $cos(37.0 * ph) + 2000.0 * $cos(5.0 * ph);
      default: v = 0.0;
    endcase
    return 16'(int'(v));
  endfunction

  // Every valid pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 32'(valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("freqbin", 32'(freqbin), 32'(e.bin));
        chk("valid_cycle", cyc, e.due);
      end
    end
  end

  task automatic send_window(input int kind, input int gap_at, input int gap_len,
                             input int bin, input bit expect_it);
    for (int n = 0; n < 128; n++) begin
      if (n == gap_at) begin
        repeat (gap_len) begin
          @(negedge clock);
          enable = 1'b0;
        end
      end
      @(negedge clock);
      enable = 1'b1;
      datain = tone(kind, n);
    end
    @(negedge clock);
    enable = 1'b0;
    datain = '0;
    if (expect_it) sb_q.push_back('{bin, cyc + LAT});
  endtask

  task automatic wait_done(input bit toggle);
    int i;
    i = 0;
    while (sb_q.size() != 0 && i < 10000) begin
      @(negedge clock);
      if (toggle && !valid) begin
        enable = 1'($urandom_range(0, 1));
        datain = 16'($urandom);
      end else begin
        enable = 1'b0;
      end
      i++;
    end
    enable = 1'b0;
    datain = '0;
    chk("done_timeout", sb_q.size(), 0);
  endtask

  initial begin
    repeat (10) @(negedge clock);
    chk("rst_freqbin", 32'(freqbin), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    reset = 1'b1;

    send_window(1, -1, 0, 10, 1'b1);   // bin-10 sine
    wait_done(1'b0);
    send_window(2, -1, 0, 37, 1'b1);   // bin-37 cosine plus weak bin 5
    wait_done(1'b0);
    send_window(1, 64, 20, 10, 1'b1);  // gapped enable
    wait_done(1'b0);
    send_window(0, -1, 0, 1, 1'b1);    // all-zero ties go to bin 1
    wait_done(1'b0);

    // abort an analysis 3000 cycles in
    send_window(2, -1, 0, 37, 1'b0);
    repeat (3000) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("abort_freqbin", 32'(freqbin), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    send_window(1, -1, 0, 10, 1'b1);
    wait_done(1'b0);

    // enable/datain noise during COMPUTE and DONE must be ignored
    send_window(2, -1, 0, 37, 1'b1);
    wait_done(1'b1);
    send_window(1, -1, 0, 10, 1'b1);
    wait_done(1'b0);

    repeat (20) @(negedge clock);
    chk("hold_freqbin", 32'(freqbin), 32'd10);
    chk("idle_valid", 32'(valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
